// File: rtl/ray_unit_scheduler_if.sv
// Shared types and the scheduler's bus interface: job request, primitive fetch,
// per-lane ray unit results and result handshake.
// Ports: slave = scheduler side, master = job issuer / ray unit / consumer side.
`ifndef BVH_AABB_TEST_UNIT_SIZE
`define BVH_AABB_TEST_UNIT_SIZE 4
`endif

package ray_unit_scheduler_pkg;
   // Signed Q16.16 fixed point.
   typedef logic signed [31:0] fixed_t;
   localparam fixed_t FIXED_INF = 32'sh7FFF_FFFF;

   typedef struct packed {
      fixed_t org_x;
      fixed_t org_y;
      fixed_t org_z;
      fixed_t dir_x;
      fixed_t dir_y;
      fixed_t dir_z;
   } ray_t;

   typedef struct packed {
      logic   b_hit;
      fixed_t t;
   } hit_t;

   function automatic fixed_t fixed_inf();
      return FIXED_INF;
   endfunction
endpackage

interface ray_unit_scheduler_if #(
   parameter int WIDTH = `BVH_AABB_TEST_UNIT_SIZE,
   parameter int CNT_W = 8
);
   import ray_unit_scheduler_pkg::*;

   logic                   start;
   logic                   any_mode;
   ray_t                   ray_in;
   logic [CNT_W-1:0]       prim_base;
   logic [CNT_W-1:0]       prim_count;
   logic                   busy;
   logic                   fetch_req;
   logic [CNT_W-1:0]       fetch_idx;
   logic                   fetch_valid;
   ray_t                   ru_ray;
   logic [WIDTH-1:0]       lane_mask;
   hit_t [WIDTH-1:0]       ru_hit;
   logic                   res_valid;
   logic                   res_ready;
   hit_t                   res_hit;
   logic                   res_any;

   modport slave (
      input  start, any_mode, ray_in, prim_base, prim_count,
      input  fetch_valid, ru_hit, res_ready,
      output busy, fetch_req, fetch_idx, ru_ray, lane_mask,
      output res_valid, res_hit, res_any
   );

   modport master (
      output start, any_mode, ray_in, prim_base, prim_count,
      output fetch_valid, ru_hit, res_ready,
      input  busy, fetch_req, fetch_idx, ru_ray, lane_mask,
      input  res_valid, res_hit, res_any
   );
endinterface

// File: rtl/ray_unit_scheduler.sv
// Walks a BVH leaf in WIDTH-primitive batches, reduces ray unit hits to closest/any hit.
// Latency: zero-count job result 1 cycle after start; N batches, no fetch wait: 2N+1 cycles.
// Backpressure: FETCH holds until fetch_valid; RESULT holds res_hit stable until res_ready.
// Ports: clk, resetn (async active-low), bus (ray_unit_scheduler_if.slave).
`ifndef BVH_AABB_TEST_UNIT_SIZE
`define BVH_AABB_TEST_UNIT_SIZE 4
`endif

module ray_unit_scheduler
   import ray_unit_scheduler_pkg::*;
#(
   parameter int WIDTH = `BVH_AABB_TEST_UNIT_SIZE,
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                resetn,
   ray_unit_scheduler_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_TEST   = 2'd2,
      S_RESULT = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
   localparam hit_t HIT_NONE = '{b_hit: 1'b0, t: FIXED_INF};

   state_t           state_q, state_d;
   logic             any_q, any_d;
   ray_t             ray_q, ray_d;
   logic [CNT_W-1:0] cursor_q, cursor_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   hit_t             acc_q, acc_d;

   logic [CNT_W-1:0] take;
   logic [WIDTH-1:0] valid_lanes;
   hit_t             win;

   // Primitives consumed by the current batch and the lanes that hold them.
   always_comb begin
      take        = (remaining_q < WIDTH_C) ? remaining_q : WIDTH_C;
      valid_lanes = '0;
      for (int i = 0; i < WIDTH; i++) begin
         valid_lanes[i] = (CNT_W'(i) < take);
      end
   end

   // Batch winner: strict '<' while scanning upward keeps the lower lane on a tie.
   always_comb begin
      win = HIT_NONE;
      for (int i = 0; i < WIDTH; i++) begin
         if (valid_lanes[i] && bus.ru_hit[i].b_hit &&
             (!win.b_hit || (bus.ru_hit[i].t < win.t))) begin
            win = bus.ru_hit[i];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      any_d       = any_q;
      ray_d       = ray_q;
      cursor_d    = cursor_q;
      remaining_d = remaining_q;
      acc_d       = acc_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               any_d       = bus.any_mode;
               ray_d       = bus.ray_in;
               cursor_d    = bus.prim_base;
               remaining_d = bus.prim_count;
               acc_d       = HIT_NONE;
               state_d     = (bus.prim_count == '0) ? S_RESULT : S_FETCH;
            end
         end
         S_FETCH: begin
            if (bus.fetch_valid) begin
               state_d = S_TEST;
            end
         end
         S_TEST: begin
            cursor_d    = cursor_q + WIDTH_C;
            remaining_d = remaining_q - take;
            if (any_q && win.b_hit) begin
               // First hitting batch ends an any-hit job; acc is still empty here.
               acc_d   = win;
               state_d = S_RESULT;
            end else begin
               // On equal T the earlier batch stays in acc.
               if (win.b_hit && (win.t < acc_q.t)) begin
                  acc_d = win;
               end
               state_d = (remaining_q == take) ? S_RESULT : S_FETCH;
            end
         end
         S_RESULT: begin
            if (bus.res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         any_q       <= 1'b0;
         ray_q       <= '0;
         cursor_q    <= '0;
         remaining_q <= '0;
         acc_q       <= HIT_NONE;
      end else begin
         state_q     <= state_d;
         any_q       <= any_d;
         ray_q       <= ray_d;
         cursor_q    <= cursor_d;
         remaining_q <= remaining_d;
         acc_q       <= acc_d;
      end
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.fetch_req = (state_q == S_FETCH);
   assign bus.fetch_idx = cursor_q;
   assign bus.ru_ray    = ray_q;
   assign bus.lane_mask = ((state_q == S_FETCH) || (state_q == S_TEST)) ? valid_lanes : '0;
   assign bus.res_valid = (state_q == S_RESULT);
   assign bus.res_hit   = acc_q;
   assign bus.res_any   = (state_q == S_RESULT) && acc_q.b_hit;

endmodule

// File: tb/tb_ray_unit_scheduler.sv
// Bench for ray_unit_scheduler: acts as job issuer, ray unit and result consumer;
// expectations come from a primitive-order model of the leaf.
module tb_ray_unit_scheduler;
   import ray_unit_scheduler_pkg::*;

   localparam int WIDTH = 4;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   ray_unit_scheduler_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   ray_unit_scheduler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int errors = 0;
   int checks = 0;

   // Leaf contents seen by the ray unit, indexed by absolute primitive index.
   logic   tab_hit [256];
   fixed_t tab_t   [256];

   // Model outputs for the current job.
   int               exp_n;
   logic [CNT_W-1:0] exp_idx [$];
   logic [WIDTH-1:0] exp_mask [$];
   hit_t             exp_hit;
   logic             exp_any;
   ray_t             exp_ray;
   int               fetch_no;

   // Quarters to Q16.16.
   function automatic fixed_t fx(input int q4);
      return fixed_t'(q4 <<< 14);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_table();
      for (int i = 0; i < 256; i++) begin
         tab_hit[i] = 1'b0;
         tab_t[i]   = fx(400);
      end
   endtask

   task automatic set_hit(input int p, input fixed_t t);
      tab_hit[p] = 1'b1;
      tab_t[p]   = t;
   endtask

   function automatic ray_t make_ray();
      ray_t r;
      r.org_x = fixed_t'($urandom);
      r.org_y = fixed_t'($urandom);
      r.org_z = fixed_t'($urandom);
      r.dir_x = fixed_t'($urandom);
      r.dir_y = fixed_t'($urandom);
      r.dir_z = fixed_t'($urandom);
      return r;
   endfunction

   // Model: closest = earliest primitive with the smallest T over the whole leaf;
   // any = smallest T within the batch holding the first hitting primitive.
   task automatic compute_model(input int base, input int count, input bit any);
      int first, nb, lo, hi, n, p;
      exp_idx.delete();
      exp_mask.delete();
      exp_hit = '{b_hit: 1'b0, t: FIXED_INF};
      first = -1;
      if (any) begin
         for (int k = 0; k < count; k++) begin
            if (first < 0 && tab_hit[(base + k) % 256]) first = k;
         end
      end
      nb = (count + WIDTH - 1) / WIDTH;
      lo = 0;
      hi = count;
      if (first >= 0) begin
         nb = first / WIDTH + 1;
         lo = (first / WIDTH) * WIDTH;
         hi = (lo + WIDTH < count) ? lo + WIDTH : count;
      end
      for (int b = 0; b < nb; b++) begin
         n = (count - b * WIDTH < WIDTH) ? count - b * WIDTH : WIDTH;
         exp_idx.push_back(CNT_W'((base + b * WIDTH) % 256));
         exp_mask.push_back(WIDTH'((1 << n) - 1));
      end
      for (int k = lo; k < hi; k++) begin
         p = (base + k) % 256;
         if (tab_hit[p] && (!exp_hit.b_hit || tab_t[p] < exp_hit.t)) begin
            exp_hit = '{b_hit: 1'b1, t: tab_t[p]};
         end
      end
      exp_any = exp_hit.b_hit;
      exp_n   = nb;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},      bus.busy, 1'b0);
      check({tag, "_fetch_req"}, bus.fetch_req, 1'b0);
      check({tag, "_res_valid"}, bus.res_valid, 1'b0);
      check({tag, "_res_any"},   bus.res_any, 1'b0);
      check({tag, "_lane_mask"}, bus.lane_mask, '0);
      check({tag, "_acc_bhit"},  bus.res_hit.b_hit, 1'b0);
      check({tag, "_acc_t"},     bus.res_hit.t, FIXED_INF);
   endtask

   // Per-cycle comparison of DUT outputs against the model.
   task automatic compare_outputs(input int lat, input int exp_lat, inout bit seen_res);
      check("busy_during_job", bus.busy, 1'b1);
      if (bus.fetch_req) begin
         if (fetch_no >= exp_n) begin
            check("extra_fetch_req", bus.fetch_req, 1'b0);
         end else begin
            check("fetch_idx", bus.fetch_idx, exp_idx[fetch_no]);
            check("lane_mask", bus.lane_mask, exp_mask[fetch_no]);
            check("ru_ray",    bus.ru_ray[63:0] ^ bus.ru_ray[191:128], exp_ray[63:0] ^ exp_ray[191:128]);
         end
      end
      if (bus.res_valid) begin
         check("res_hit_bhit", bus.res_hit.b_hit, exp_hit.b_hit);
         check("res_hit_t",    bus.res_hit.t, exp_hit.t);
         check("res_any",      bus.res_any, exp_any);
         if (!seen_res && exp_lat >= 0) check("latency", lat, exp_lat);
         seen_res = 1'b1;
      end
   endtask

   task automatic run_job(input int base, input int count, input bit any,
                          input int fetch_delay, input int ready_delay,
                          input bit pester, input int rst_batch, input int exp_lat);
      bit               done, aborted, serve, seen_res;
      int               fwait, rwait, lat, cyc;
      logic [CNT_W-1:0] srv_idx, p;
      logic [WIDTH-1:0] srv_mask;

      compute_model(base, count, any);
      exp_ray  = make_ray();
      fetch_no = 0;

      bus.start      = 1'b1;
      bus.any_mode   = any;
      bus.ray_in     = exp_ray;
      bus.prim_base  = CNT_W'(base);
      bus.prim_count = CNT_W'(count);
      step();
      bus.start  = 1'b0;
      bus.ray_in = make_ray();

      done = 0; aborted = 0; serve = 0; seen_res = 0;
      fwait = 0; rwait = 0; lat = 1; cyc = 0;
      srv_idx = '0; srv_mask = '0;
      while (!done && cyc < 300) begin
         // Ray unit: bogus hits everywhere except valid lanes of the batch under test.
         for (int i = 0; i < WIDTH; i++) bus.ru_hit[i] = '{b_hit: 1'b1, t: fx(2)};
         if (serve) begin
            for (int i = 0; i < WIDTH; i++) begin
               p = srv_idx + CNT_W'(i);
               if (srv_mask[i]) bus.ru_hit[i] = '{b_hit: tab_hit[p], t: tab_t[p]};
               else             bus.ru_hit[i] = '{b_hit: 1'b1, t: fx(4)};
            end
            if (fetch_no == rst_batch) begin
               resetn = 1'b0;
               #1;
               check_reset_outputs("midjob_reset");
               bus.fetch_valid = 1'b0;
               bus.res_ready   = 1'b0;
               bus.start       = 1'b0;
               step();
               step();
               resetn = 1'b1;
               for (int k = 0; k < 5; k++) begin
                  step();
                  check("post_reset_no_result", bus.res_valid, 1'b0);
                  check("post_reset_no_fetch",  bus.fetch_req, 1'b0);
               end
               aborted = 1;
               done    = 1;
            end
         end
         serve = 0;
         if (!aborted) begin
            compare_outputs(lat, exp_lat, seen_res);
            bus.fetch_valid = 1'b0;
            bus.res_ready   = 1'b0;
            if (bus.fetch_req && fetch_no < exp_n) begin
               if (fwait >= fetch_delay) begin
                  bus.fetch_valid = 1'b1;
                  serve    = 1;
                  srv_idx  = exp_idx[fetch_no];
                  srv_mask = exp_mask[fetch_no];
                  fetch_no++;
                  fwait = 0;
               end else begin
                  fwait++;
               end
            end
            if (bus.res_valid) begin
               if (rwait >= ready_delay) begin
                  bus.res_ready = 1'b1;
                  done = 1;
               end else begin
                  rwait++;
               end
            end
            bus.start = 1'b0;
            if (pester && !done && (cyc % 3 == 1)) begin
               bus.start      = 1'b1;
               bus.any_mode   = 1'($urandom);
               bus.prim_base  = CNT_W'($urandom);
               bus.prim_count = CNT_W'($urandom_range(1, 40));
            end
            step();
            lat++;
            cyc++;
         end
      end
      bus.start       = 1'b0;
      bus.res_ready   = 1'b0;
      bus.fetch_valid = 1'b0;
      if (!aborted) begin
         if (!done) check("job_timeout", done, 1'b1);
         check("busy_after_result", bus.busy, 1'b0);
         check("fetch_count", fetch_no, exp_n);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn          = 1'b0;
      bus.start       = 1'b0;
      bus.any_mode    = 1'b0;
      bus.ray_in      = '0;
      bus.prim_base   = '0;
      bus.prim_count  = '0;
      bus.fetch_valid = 1'b0;
      bus.res_ready   = 1'b0;
      for (int i = 0; i < WIDTH; i++) bus.ru_hit[i] = '{b_hit: 1'b1, t: fx(2)};
      step();
      step();
      check_reset_outputs("reset");
      resetn = 1'b1;
      step();

      // Closest, 10 prims, single hit at prim 6 of the leaf.
      clear_table();
      set_hit(26, fx(20));
      run_job(20, 10, 1'b0, 0, 0, 1'b0, 0, 7);
      check("pin_t1_nfetch", exp_n, 3);
      check("pin_t1_mask2", exp_mask[2], 4'b0011);
      check("pin_t1_idx2", exp_idx[2], 8'd28);
      check("pin_t1_t", exp_hit.t, 32'sh0005_0000);

      // Any-hit, hits first appear in batch 2; batch 3 has a closer hit that must not be fetched.
      clear_table();
      set_hit(5, fx(12));
      set_hit(6, fx(8));
      set_hit(7, fx(8));
      set_hit(9, fx(4));
      run_job(0, 12, 1'b1, 0, 0, 1'b0, 0, 5);
      check("pin_t2_nfetch", exp_n, 2);
      check("pin_t2_t", exp_hit.t, 32'sh0002_0000);

      // Empty leaf.
      clear_table();
      run_job(50, 0, 1'b0, 0, 0, 1'b0, 0, 1);
      check("pin_t3_t", exp_hit.t, 32'sh7FFF_FFFF);
      check("pin_t3_nfetch", exp_n, 0);

      // Masked lanes of the last batch report closer bogus hits.
      clear_table();
      set_hit(101, fx(20));
      set_hit(102, fx(28));
      set_hit(104, fx(16));
      run_job(100, 6, 1'b0, 0, 0, 1'b0, 0, 5);
      check("pin_t4_t", exp_hit.t, 32'sh0004_0000);
      check("pin_t4_mask1", exp_mask[1], 4'b0011);

      // Index wrap, slow fetch, slow consumer, start pulses while busy.
      clear_table();
      set_hit(251, fx(14));
      set_hit(0, fx(9));
      set_hit(3, fx(4));
      run_job(250, 9, 1'b0, 5, 3, 1'b1, 0, -1);
      check("pin_t5_idx2", exp_idx[2], 8'd2);
      check("pin_t5_t", exp_hit.t, 32'sh0002_4000);

      // Reset during the second batch's test cycle, then fresh jobs.
      clear_table();
      set_hit(5, fx(8));
      run_job(0, 8, 1'b0, 0, 0, 1'b0, 2, -1);
      check_reset_outputs("after_abort");
      run_job(0, 8, 1'b0, 0, 0, 1'b0, 0, 5);
      check("pin_t6_t", exp_hit.t, 32'sh0002_0000);
      clear_table();
      run_job(30, 5, 1'b1, 0, 0, 1'b0, 0, 5);
      check("pin_t7_nfetch", exp_n, 2);
      check("pin_t7_any", exp_any, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ray_unit_scheduler.md
RAY_UNIT_SCHEDULER -- requirements
Module: ray_unit_scheduler

Interface
REQ-001 Parameter WIDTH, default `BVH_AABB_TEST_UNIT_SIZE, SHALL set the primitives tested per batch (lanes of the ray unit).
REQ-002 Parameter CNT_W, default 8, SHALL set the width of primitive counts and indices.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 resetn  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  in  1  SHALL request a new job; accepted only when busy=0.
REQ-006 any_mode  in  1  SHALL select any-hit (1) or closest-hit (0); sampled with start.
REQ-007 ray_in  in  Ray  SHALL be the job ray; sampled with start.
REQ-008 prim_base, prim_count  in  CNT_W each  SHALL give the first primitive index and the primitive count of the leaf; sampled with start.
REQ-009 busy  out  1  SHALL be high from the cycle after start acceptance until the result is consumed.
REQ-010 fetch_req  out  1, fetch_idx  out  CNT_W  SHALL request a WIDTH-primitive batch starting at fetch_idx.
REQ-011 fetch_valid  in  1  SHALL mark batch data present on the ray unit's primitive inputs; ignored unless fetch_req=1.
REQ-012 ru_ray  out  Ray  SHALL drive the latched job ray to the ray unit.
REQ-013 lane_mask  out  WIDTH  SHALL mark lanes holding valid primitives in the current batch.
REQ-014 ru_hit  in  HitData (per lane, WIDTH)  SHALL be the ray unit's per-lane hit results.
REQ-015 res_valid  out  1, res_ready  in  1, res_hit  out  HitData, res_any  out  1  SHALL form the result handshake.

Function
REQ-016 States SHALL be IDLE, FETCH, TEST, RESULT.
REQ-017 IDLE: start=1 SHALL latch inputs, set acc.bHit=0, acc.T=FixedInf(), cursor=prim_base, remaining=prim_count, and go to FETCH; if prim_count=0, go directly to RESULT.
REQ-018 FETCH: fetch_req=1, fetch_idx=cursor; fetch_idx SHALL stay stable until fetch_valid=1, which moves to TEST the next cycle.
REQ-019 Fetch latency SHALL be unbounded; FETCH holds with no timeout.
REQ-020 lane_mask bit i SHALL be 1 iff i < min(remaining, WIDTH).
REQ-021 TEST (exactly one cycle) SHALL ignore masked-off lanes and take the lowest-index unmasked lane with bHit=1 and the smallest T as the batch winner; ties keep the lower lane.
REQ-022 The winner SHALL replace acc only if bHit=1 and winner.T < acc.T (strict Fixed compare); on equal T the earlier batch is kept.
REQ-023 After TEST, cursor += WIDTH and remaining -= min(remaining, WIDTH); remaining=0 goes to RESULT, otherwise FETCH.
REQ-024 Any mode: if any unmasked lane has bHit=1 in TEST, SHALL go to RESULT immediately with res_any=1 and res_hit = that batch winner.
REQ-025 Closest mode: res_any SHALL equal acc.bHit.
REQ-026 RESULT: res_valid=1 with res_hit/res_any stable until res_ready=1, then return to IDLE; busy falls the same cycle.
REQ-027 start while busy=1 SHALL be ignored without corrupting the job.
REQ-028 cursor arithmetic SHALL wrap modulo 2^CNT_W.
REQ-029 Latency: zero-count job, res_valid in the cycle after start; otherwise N batches with zero fetch wait give res_valid 2N+1 cycles after start.

Reset
REQ-030 resetn=0 SHALL immediately force IDLE, busy=0, fetch_req=0, res_valid=0, res_any=0, lane_mask=0, acc.bHit=0, acc.T=FixedInf().
REQ-031 Reset mid-job SHALL abandon the job; no result is emitted after release.

Verification
REQ-032 WIDTH=4, closest mode, count=10, hit only in prim 6 (T=5.0) -> 3 fetches at base, +4, +8; lane_mask 1111,1111,0011; res_hit.T=5.0, res_any=1.
REQ-033 Any mode, count=12, hits in batch 2 only -> exactly 2 fetches, res_any=1, no third fetch_req.
REQ-034 count=0 -> no fetch_req, res_valid the next cycle, res_hit.bHit=0, res_hit.T=FixedInf().
REQ-035 count=6, lane 3 of batch 2 (masked) reports bHit=1 T=1.0, real hit T=4.0 -> res_hit.T=4.0.
REQ-036 fetch_valid delayed 5 cycles, res_ready held low 3 cycles -> fetch_idx and res_hit stable throughout; start pulses during busy are ignored.
REQ-037 resetn pulsed low during TEST of batch 2 -> all outputs at reset values; a new job after release completes correctly.
